// File: rtl/serial_adder4_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_adder4_pkg;

  localparam int unsigned ADD_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Bit counter must hold WIDTH-1 for any legal WIDTH, including WIDTH=1.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/serial_adder4_fulladder.sv
// Single-bit full adder cell driven one bit pair per clock by serial_adder4.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  always_comb begin
    s  = a ^ b ^ c;
    co = (a & b) | (a & c) | (b & c);
  end

endmodule

// File: rtl/serial_adder4.sv
// Bit-serial adder: captures operands on start, adds one bit per clock LSB first
// through a single fulladder, and presents a registered sum/cout with a done pulse.
module serial_adder4
  import serial_adder4_pkg::*;
#(
  parameter int unsigned WIDTH = ADD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-1:0]   sum_sr_q, sum_sr_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;

  logic               fa_s;
  logic               fa_co;
  logic [WIDTH-1:0]   sum_shift;

  fulladder FA (
    .a  (a_sr_q[0]),
    .b  (b_sr_q[0]),
    .c  (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    // New sum bit enters at the MSB; built with a shift so WIDTH=1 needs no slice.
    sum_shift            = sum_sr_q >> 1;
    sum_shift[WIDTH-1]   = fa_s;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RUN;
          a_sr_d   = a;
          b_sr_d   = b;
          carry_d  = cin;
          cnt_d    = '0;
          sum_sr_d = '0;
          busy_d   = 1'b1;
        end
      end
      S_RUN: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        sum_sr_d = sum_shift;
        carry_d  = fa_co;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          sum_d   = sum_shift;
          cout_d  = fa_co;
        end else begin
          busy_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder4.sv
// Directed and exhaustive self-checking bench for serial_adder4 at WIDTH=4.
module tb_serial_adder4;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  logic [W:0] prev;

  always #5 clk = ~clk;

  serial_adder4 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One complete add; inject>0 pulses a stray start that many cycles into RUN.
  task automatic do_add(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                        input logic [W:0] exp, input int inject);
    int cyc;
    a = ia; b = ib; cin = ic; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = ~ia; b = ~ib; cin = ~ic;
    check("busy_accept", busy, 1);
    check("done_accept", done, 0);
    check("sum_hold", {cout, sum}, prev);
    cyc = 0;
    while (done !== 1'b1 && cyc < int'(W) + 4) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == inject) begin
        start = 1'b1; a = 1; b = 1;
      end else begin
        start = 1'b0;
      end
      if (done !== 1'b1) check("busy_run", busy, 1);
    end
    check("done_lat", cyc, W);
    check("busy_done", busy, 0);
    check("result", {cout, sum}, exp);
    prev = exp;
    @(posedge clk); #1;
    check("done_pulse", done, 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    int base;
    logic [W:0] model;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; prev = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    rst_n = 1'b1;

    do_add(4'h0, 4'h0, 1'b0, 5'h00, 0);
    do_add(4'h5, 4'h3, 1'b0, 5'h08, 0);
    do_add(4'hF, 4'h1, 1'b0, 5'h10, 0);

    base = done_cnt;
    do_add(4'hF, 4'hF, 1'b1, 5'h1F, 2);
    repeat (3) @(posedge clk);
    #1;
    check("inject_done_cnt", done_cnt - base, 1);
    check("inject_busy", busy, 0);
    check("inject_result", {cout, sum}, 5'h1F);

    a = 4'h9; b = 4'h9; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("abort_busy_run", busy, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    base = done_cnt;
    @(posedge clk); #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 0);
    rst_n = 1'b1;
    repeat (W + 2) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt - base, 0);
    prev = '0;
    do_add(4'h9, 4'h9, 1'b0, 5'h12, 0);

    base = done_cnt;
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      model = 5'(v[3:0]) + 5'(v[7:4]) + 5'(v[8]);
      do_add(v[3:0], v[7:4], v[8], model, 0);
    end
    check("exh_done_cnt", done_cnt - base, 512);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
